// File: rtl/bus_reg_responder.sv
// Sequential register-bus responder: 16x4 register file behind a valid/ready handshake
// with a fixed number of wait states and a single-cycle ready pulse per access.
module bus_reg_responder #(
    parameter int         WAIT_CYCLES = 2,
    parameter logic [3:0] RESET_VAL   = 4'h0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       valid,
    input  logic       wen,
    input  logic [3:0] addr,
    input  logic [3:0] wdata,
    output logic [3:0] rdata,
    output logic       ready,
    output logic [4:0] bus_out
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t     state;
    state_t     state_next;
    logic [2:0] wait_cnt;
    logic       wen_q;
    logic [3:0] addr_q;
    logic [3:0] wdata_q;
    logic [3:0] count;
    logic [3:0] mem [16];

    logic       accept;
    logic       enter_resp;
    logic       acc_wen;
    logic [3:0] acc_addr;
    logic [3:0] acc_wdata;

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (valid) begin
                    accept     = 1'b1;
                    state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt <= 3'd1) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // With zero wait states RESP is entered straight from IDLE, so the live request is used
    assign enter_resp = (state != RESP) && (state_next == RESP);
    assign acc_wen    = accept ? wen   : wen_q;
    assign acc_addr   = accept ? addr  : addr_q;
    assign acc_wdata  = accept ? wdata : wdata_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= 3'd0;
            wen_q    <= 1'b0;
            addr_q   <= 4'h0;
            wdata_q  <= 4'h0;
            count    <= 4'h0;
            rdata    <= 4'h0;
        end else begin
            state <= state_next;
            if (accept) begin
                wen_q    <= wen;
                addr_q   <= addr;
                wdata_q  <= wdata;
                wait_cnt <= 3'(WAIT_CYCLES);
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt - 3'd1;
            end
            if (enter_resp) begin
                rdata <= acc_wen ? acc_wdata : mem[acc_addr];
            end
            if (state == RESP) begin
                count <= count + 4'd1;
            end
        end
    end

    // Write commits on RESP entry so a following read of the same address sees it
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                mem[i] <= RESET_VAL;
            end
        end else if (enter_resp && acc_wen) begin
            mem[acc_addr] <= acc_wdata;
        end
    end

    assign ready   = (state == RESP);
    assign bus_out = {state != IDLE, count};

endmodule

// File: tb/tb_bus_reg_responder.sv
// Bench for bus_reg_responder: table-driven transactions on a 2-wait-state instance,
// hand-written abort and back-to-back sequences, and a scoreboard queue for rdata.
module tb_bus_reg_responder;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       rst2 = 1'b1, valid2 = 1'b0, wen2 = 1'b0;
    logic [3:0] addr2 = 4'h0, wdata2 = 4'h0, rdata2;
    logic       ready2;
    logic [4:0] bus2;

    logic       rst0 = 1'b1, valid0 = 1'b0, wen0 = 1'b0;
    logic [3:0] addr0 = 4'h0, wdata0 = 4'h0, rdata0;
    logic       ready0;
    logic [4:0] bus0;

    bus_reg_responder #(.WAIT_CYCLES(2), .RESET_VAL(4'h0)) dut2 (
        .clock(clock), .reset(rst2), .valid(valid2), .wen(wen2), .addr(addr2),
        .wdata(wdata2), .rdata(rdata2), .ready(ready2), .bus_out(bus2)
    );

    bus_reg_responder #(.WAIT_CYCLES(0), .RESET_VAL(4'h0)) dut0 (
        .clock(clock), .reset(rst0), .valid(valid0), .wen(wen0), .addr(addr0),
        .wdata(wdata0), .rdata(rdata0), .ready(ready0), .bus_out(bus0)
    );

    typedef struct {
        logic       w;
        logic [3:0] a;
        logic [3:0] d;
        logic       perturb;
        logic [3:0] exp_rd;
        logic [3:0] exp_cnt;
    } vec_t;

    vec_t       vecs [11];
    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [3:0] q2 [$];
    logic [3:0] q0 [$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Scoreboard: every ready pulse consumes one expected rdata
    always @(negedge clock) begin
        if (ready2 === 1'b1) begin
            if (q2.size() == 0) flag("dut2 unexpected ready");
            else check("dut2 rdata", {4'h0, rdata2}, {4'h0, q2.pop_front()});
        end
        if (ready0 === 1'b1) begin
            if (q0.size() == 0) flag("dut0 unexpected ready");
            else check("dut0 rdata", {4'h0, rdata0}, {4'h0, q0.pop_front()});
        end
    end

    task automatic txn2(input vec_t v);
        int k;
        bit got;
        q2.push_back(v.exp_rd);
        @(posedge clock); #1;
        valid2 = 1'b1; wen2 = v.w; addr2 = v.a; wdata2 = v.d;
        got = 1'b0;
        k = 0;
        while (!got && k < 20) begin
            @(negedge clock);
            if (ready2 === 1'b1) begin
                got = 1'b1;
            end else begin
                check("dut2 busy before resp", {7'd0, bus2[4]}, (k >= 1) ? 8'd1 : 8'd0);
                if (v.perturb && k == 1) begin
                    addr2 = 4'h9; wdata2 = 4'hF;
                end
                k++;
            end
        end
        if (!got) begin
            flag("dut2 ready timeout");
        end else begin
            check("dut2 latency", 8'(k), 8'd3);
            check("dut2 bus_out in resp", {3'd0, bus2}, {3'd0, 1'b1, v.exp_cnt - 4'd1});
        end
        @(posedge clock); #1;
        valid2 = 1'b0;
        @(negedge clock);
        check("dut2 bus_out after resp", {3'd0, bus2}, {4'd0, v.exp_cnt});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 4'h3, 4'hA, 1'b0, 4'hA, 4'h1};
        vecs[1]  = '{1'b0, 4'h3, 4'h0, 1'b0, 4'hA, 4'h2};
        vecs[2]  = '{1'b0, 4'h4, 4'h0, 1'b0, 4'h0, 4'h3};
        vecs[3]  = '{1'b1, 4'h4, 4'h5, 1'b0, 4'h5, 4'h4};
        vecs[4]  = '{1'b0, 4'h4, 4'h0, 1'b0, 4'h5, 4'h5};
        vecs[5]  = '{1'b1, 4'hF, 4'hC, 1'b0, 4'hC, 4'h6};
        vecs[6]  = '{1'b0, 4'hF, 4'h0, 1'b0, 4'hC, 4'h7};
        vecs[7]  = '{1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h8};
        vecs[8]  = '{1'b1, 4'h1, 4'h2, 1'b1, 4'h2, 4'h9};
        vecs[9]  = '{1'b0, 4'h1, 4'h0, 1'b0, 4'h2, 4'hA};
        vecs[10] = '{1'b0, 4'h9, 4'h0, 1'b0, 4'h0, 4'hB};

        repeat (2) @(negedge clock);
        rst2 = 1'b0;
        rst0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("reset ready", {7'd0, ready2}, 8'd0);
            check("reset rdata", {4'd0, rdata2}, 8'd0);
            check("reset bus_out", {3'd0, bus2}, 8'd0);
            check("reset dut0 bus_out", {2'd0, ready0, bus0}, 8'd0);
        end

        for (int i = 0; i < 11; i++) begin
            txn2(vecs[i]);
        end

        // Reset pulsed while a write to 7 sits in WAIT
        @(posedge clock); #1;
        valid2 = 1'b1; wen2 = 1'b1; addr2 = 4'h7; wdata2 = 4'h5;
        @(negedge clock);
        @(negedge clock);
        check("abort busy before reset", {7'd0, bus2[4]}, 8'd1);
        rst2 = 1'b1;
        valid2 = 1'b0;
        #1;
        check("abort bus_out in reset", {3'd0, bus2}, 8'd0);
        @(negedge clock);
        rst2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("abort no ready", {7'd0, ready2}, 8'd0);
            check("abort bus_out", {3'd0, bus2}, 8'd0);
        end
        txn2('{1'b0, 4'h7, 4'h0, 1'b0, 4'h0, 4'h1});
        txn2('{1'b0, 4'h3, 4'h0, 1'b0, 4'h0, 4'h2});

        // Zero wait states, valid held for 16 back-to-back reads
        for (int i = 0; i < 16; i++) q0.push_back(4'h0);
        @(posedge clock); #1;
        valid0 = 1'b1; wen0 = 1'b0; addr0 = 4'h5;
        for (int k = 0; k < 32; k++) begin
            @(negedge clock);
            check("dut0 ready pattern", {7'd0, ready0}, (k % 2 == 1) ? 8'd1 : 8'd0);
            if (k == 30) check("dut0 count before wrap", {3'd0, bus0}, 8'h0F);
            if (k == 31) check("dut0 bus_out last resp", {3'd0, bus0}, 8'h1F);
        end
        @(posedge clock); #1;
        valid0 = 1'b0;
        @(negedge clock);
        check("dut0 count wrapped", {3'd0, bus0}, 8'h00);
        @(negedge clock);
        check("dut0 idle after release", {2'd0, ready0, bus0}, 8'h00);

        check("dut2 scoreboard drained", 8'(q2.size()), 8'd0);
        check("dut0 scoreboard drained", 8'(q0.size()), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_reg_responder.md
# bus_reg_responder

Sequential responder for the four-bit valid/ready register bus: a 16-entry by 4-bit register file that accepts one transaction at a time, inserts a configurable number of wait states, and completes each access with a single-cycle `ready` pulse. It sits behind any bus initiator in place of the zero-latency combinational responder, giving initiators real back-pressure and stateful storage. A status word on `bus_out` exposes the busy flag and a completed-transaction count.

## Interface

Parameters:
- `WAIT_CYCLES`, default 2: wait states inserted between acceptance and response; legal range 0..7.
- `RESET_VAL`, default 4'h0: value loaded into every register-file entry on reset.

Ports:
- `clock`  input  1  single clock; all state updates on its rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `valid`  input  1  initiator request; held high until `ready` is seen.
- `wen`  input  1  1 = write, 0 = read; qualified by `valid`.
- `addr`  input  4  register index 0..15.
- `wdata`  input  4  write data.
- `rdata`  output  4  response data; meaningful only while `ready` = 1.
- `ready`  output  1  one-cycle completion pulse.
- `bus_out`  output  5  status: bit 4 is busy (state ≠ IDLE); bits 3:0 are the completed-transaction count.

## Operation

- There are 16 entries of 4 bits each, `mem[0..15]`, and all are loaded with `RESET_VAL` on reset.
- The state machine has three states: IDLE, WAIT, RESP.
  - IDLE: when `valid` = 1 at a clock edge, latch `addr`, `wen` and `wdata` and load the wait counter with `WAIT_CYCLES`. If `WAIT_CYCLES` = 0, go to RESP; otherwise go to WAIT. When `valid` = 0, stay in IDLE.
  - WAIT: decrement the counter on each edge. When the counter is 1 at an edge, go to RESP. Request inputs are ignored in this state; they are already latched.
  - RESP: `ready` = 1 for exactly this cycle. Always return to IDLE on the next edge.
- Writes:
  - The write is committed to `mem[addr_q]` on the edge that enters RESP.
  - During RESP, `rdata` = `wdata_q` (echo).
- Reads:
  - `rdata` is registered from `mem[addr_q]` on the edge that enters RESP.
- Transaction counter:
  - Increments by 1 on the edge that leaves RESP.
  - Four-bit, wraps from 15 to 0.
- `rdata` keeps its last registered value outside RESP. Initiators must not use it outside RESP.
- Handshake rules:
  - The initiator holds `valid`, `wen`, `addr` and `wdata` stable until it sees `ready`.
  - The responder only samples these signals in IDLE.
  - If `valid` is still high in the cycle after RESP, it is a new transaction and is accepted from IDLE. Back-to-back transactions are therefore legal, with one IDLE cycle between them.
- Reset asserted mid-transaction:
  - The state returns to IDLE immediately.
  - The pending write is discarded and all of `mem` returns to `RESET_VAL`.
  - The count is cleared. No `ready` pulse is produced for the aborted transaction.

## Timing

- Reset values: `ready` = 0, `rdata` = 4'h0, `bus_out` = 5'h00, state = IDLE, counter = 0.
- All outputs are registered or decoded from registered state only. There is no combinational path from inputs to outputs.
- Latency: with `valid` first high in cycle N (sampled in IDLE), `ready` is high in cycle N + `WAIT_CYCLES` + 1.
- `bus_out[4]` is 1 from cycle N+1 through the RESP cycle, inclusive.
- Maximum throughput: one transaction every `WAIT_CYCLES` + 2 cycles.
- A read of an address in the cycle after a write to that same address returns the new value, because the write is already committed on RESP entry.
- Reset deasserted: the first accept can occur on the first rising edge after deassertion.

## Test plan

- Reset, then idle for 5 cycles: `ready` = 0, `rdata` = 0, `bus_out` = 5'h00 throughout.
- `WAIT_CYCLES` = 2, write addr 4'h3, data 4'hA:
  - `valid` high in cycle 0 gives `ready` only in cycle 3, with `rdata` = 4'hA.
  - `bus_out` = 5'h10 in cycles 1–3, then 5'h01.
- Read addr 4'h3 after that write: `rdata` = 4'hA in the `ready` cycle. A read of addr 4'h4 returns `RESET_VAL` (4'h0).
- `WAIT_CYCLES` = 0, `valid` held high for 16 back-to-back reads:
  - `ready` pulses every 2nd cycle.
  - The count wraps to 4'h0 after the 16th transaction, so `bus_out` = 5'h00.
- Reset pulsed during WAIT of a write to addr 4'h7 with data 4'h5:
  - No `ready` pulse is produced and `bus_out` = 5'h00.
  - A subsequent read of addr 4'h7 returns 4'h0.
- Inputs changed during WAIT (addr 4'h1 → 4'h9, wdata 4'h2 → 4'hF): the response and the committed write use the latched addr 4'h1 and data 4'h2.
